// File: rtl/gpio_modport.sv
// GPIO input capture: polarity-corrects the pin vector, registers it, flags
// per-bit rising/falling edges and keeps a saturating count of changed captures.
module gpio_modport #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_pin,
  input  logic [WIDTH-1:0] invert_mask,
  input  logic             hold,
  input  logic             clr_count,
  output logic [WIDTH-1:0] gpio_pin_passive,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [CNT_W-1:0] change_count
);

  logic [WIDTH-1:0] passive_q, passive_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] cur;
  logic             diff;

  // The mask is applied before comparison, so a mask change alone is a pin change.
  assign cur  = gpio_pin ^ invert_mask;
  assign diff = |(cur ^ passive_q);

  always_comb begin
    passive_d = passive_q;
    rise_d    = '0;
    fall_d    = '0;
    changed_d = 1'b0;
    count_d   = count_q;
    if (!hold) begin
      passive_d = cur;
      rise_d    = cur & ~passive_q;
      fall_d    = passive_q & ~cur;
      changed_d = diff;
      if (diff && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
    end
    // Clear wins over a simultaneous increment.
    if (clr_count) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      passive_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      passive_q <= passive_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      count_q   <= count_d;
    end
  end

  assign gpio_pin_passive = passive_q;
  assign rise             = rise_q;
  assign fall             = fall_q;
  assign changed          = changed_q;
  assign change_count     = count_q;

endmodule

// File: tb/tb_gpio_modport.sv
// Directed self-checking bench for gpio_modport, built with a 4-bit counter
// so saturation is reachable in a few cycles.
module tb_gpio_modport;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] gpio_pin;
  logic [WIDTH-1:0] invert_mask;
  logic             hold;
  logic             clr_count;
  logic [WIDTH-1:0] gpio_pin_passive;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [CNT_W-1:0] change_count;

  int checkCount;
  int errorCount;

  gpio_modport #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .gpio_pin         (gpio_pin),
    .invert_mask      (invert_mask),
    .hold             (hold),
    .clr_count        (clr_count),
    .gpio_pin_passive (gpio_pin_passive),
    .rise             (rise),
    .fall             (fall),
    .changed          (changed),
    .change_count     (change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the active edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [WIDTH-1:0] expPassive,
                          input logic [WIDTH-1:0] expRise, input logic [WIDTH-1:0] expFall,
                          input logic expChanged, input logic [CNT_W-1:0] expCount);
    checkOutput({tag, ".passive"}, 64'(gpio_pin_passive), 64'(expPassive));
    checkOutput({tag, ".rise"}, 64'(rise), 64'(expRise));
    checkOutput({tag, ".fall"}, 64'(fall), 64'(expFall));
    checkOutput({tag, ".changed"}, 64'(changed), 64'(expChanged));
    checkOutput({tag, ".count"}, 64'(change_count), 64'(expCount));
  endtask

  initial begin
    int expCount;
    checkCount  = 0;
    errorCount  = 0;
    rst         = 1'b1;
    gpio_pin    = 32'hFFFF_FFFF;
    invert_mask = '0;
    hold        = 1'b0;
    clr_count   = 1'b0;
    #1;

    applyStimulus();
    applyStimulus();
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    rst = 1'b0;
    applyStimulus();
    checkAll("release", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'd1);

    gpio_pin = 32'h0000_00F0;
    applyStimulus();
    checkAll("capF0", 32'h0000_00F0, 32'h0, 32'hFFFF_FF0F, 1'b1, 4'd2);
    gpio_pin = 32'h0000_000F;
    applyStimulus();
    checkAll("cap0F", 32'h0000_000F, 32'h0000_000F, 32'h0000_00F0, 1'b1, 4'd3);

    gpio_pin    = 32'h0;
    invert_mask = 32'h8000_0001;
    applyStimulus();
    checkAll("invert", 32'h8000_0001, 32'h8000_0000, 32'h0000_000E, 1'b1, 4'd4);
    applyStimulus();
    checkAll("stable", 32'h8000_0001, 32'h0, 32'h0, 1'b0, 4'd4);

    invert_mask = 32'h0;
    applyStimulus();
    checkAll("maskOnly", 32'h0, 32'h0, 32'h8000_0001, 1'b1, 4'd5);

    gpio_pin = 32'hA5A5_A5A5;
    applyStimulus();
    checkAll("loadA5", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b1, 4'd6);
    hold     = 1'b1;
    gpio_pin = 32'h5A5A_5A5A;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkAll("hold", 32'hA5A5_A5A5, 32'h0, 32'h0, 1'b0, 4'd6);
    end
    hold = 1'b0;
    applyStimulus();
    checkAll("unhold", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 1'b1, 4'd7);

    hold = 1'b1;
    rst  = 1'b1;
    applyStimulus();
    checkAll("midReset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    rst      = 1'b0;
    hold     = 1'b0;
    gpio_pin = 32'h0;
    applyStimulus();
    checkAll("postReset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    for (int i = 0; i < 20; i++) begin
      gpio_pin = (i % 2 == 0) ? 32'h1 : 32'h0;
      applyStimulus();
      expCount = (i + 1 > 15) ? 15 : i + 1;
      checkOutput("toggleCount", 64'(change_count), 64'(expCount));
    end
    checkOutput("toggleChanged", 64'(changed), 64'h1);

    clr_count = 1'b1;
    gpio_pin  = 32'h1;
    applyStimulus();
    checkAll("clrPriority", 32'h1, 32'h1, 32'h0, 1'b1, 4'd0);
    clr_count = 1'b0;
    gpio_pin  = 32'h0;
    applyStimulus();
    checkAll("afterClr", 32'h0, 32'h0, 32'h1, 1'b1, 4'd1);
    hold      = 1'b1;
    clr_count = 1'b1;
    gpio_pin  = 32'h1;
    applyStimulus();
    checkAll("holdClr", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
